// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions (poly 0xAB, init 0x00, MSB-first, no reflection,
// no final XOR), used by the frame transmitter and the downstream checker.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'hAB;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {IDLE, DATA, WAIT, CRC} state_t;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    return {crc[6:0], 1'b0} ^ ((bit_in ^ crc[7]) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_bit_engine.sv
// Single-bit CRC-8 register: synchronous clear and clock enable in the clk domain,
// standing in for a strobe-clocked CRC register.
module crc8_bit_engine
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/crc8_frame_tx.sv
// Byte-to-bit frame transmitter: serializes payload bytes MSB-first on a strobed
// bit line, tracks CRC-8 in-clock and appends the CRC byte to close each frame.
module crc8_frame_tx
  import crc8_pkg::*;
#(
  parameter int BIT_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       tx_bit,
  output logic       tx_strb,
  output logic       tx_sof,
  output logic       tx_eof,
  output logic       tx_busy,
  output logic [7:0] crc_out,
  output state_t     dbg_state
);

  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_DIV - 1);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shreg, shreg_d;
  logic            last_q, last_d;
  logic            tx_bit_d, strb_d, sof_d, eof_d, busy_d;
  logic            bit_end, byte_end, xfer, load, crc_clr, crc_en;
  logic [7:0]      crc_final;

  // Handshake: a byte transfers on a rising edge where din_valid && din_ready.
  // din_ready is decoded from state/counter only, so din_valid never feeds it.
  assign bit_end   = (cnt == CNT_MAX);
  assign byte_end  = bit_end && (bit_idx == 3'd7);
  assign din_ready = !rst && ((state == IDLE) || (state == WAIT) ||
                              ((state == DATA) && byte_end && !last_q));
  assign xfer      = din_valid && din_ready;
  // With BIT_DIV=1 the last data bit's CRC step lands on the same edge we load the CRC byte.
  assign crc_final = tx_strb ? crc8_step(crc_out, tx_bit) : crc_out;
  assign crc_en    = (state == DATA) && tx_strb;
  assign dbg_state = state;

  always_comb begin
    state_d   = state;
    cnt_d     = bit_end ? '0 : cnt + CW'(1);
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    last_d    = last_q;
    strb_d    = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    busy_d    = tx_busy;
    crc_clr   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (xfer) begin
          load    = 1'b1;
          sof_d   = 1'b1;
          busy_d  = 1'b1;
          crc_clr = 1'b1;
          state_d = DATA;
        end
      end
      WAIT: begin
        cnt_d = '0;
        if (xfer) begin
          load    = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx != 3'd7) begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {shreg[6:0], 1'b0};
            strb_d    = 1'b1;
          end else if (last_q) begin
            bit_idx_d = 3'd0;
            shreg_d   = crc_final;
            strb_d    = 1'b1;
            state_d   = CRC;
          end else if (xfer) begin
            load = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      CRC: begin
        if (bit_end) begin
          if (bit_idx != 3'd7) begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {shreg[6:0], 1'b0};
            strb_d    = 1'b1;
            eof_d     = (bit_idx == 3'd6);
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shreg_d   = din;
      last_d    = din_last;
      bit_idx_d = 3'd0;
      cnt_d     = '0;
      strb_d    = 1'b1;
    end
    // A new bit period always presents the current MSB; otherwise the line holds.
    tx_bit_d = strb_d ? shreg_d[7] : tx_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      last_q  <= 1'b0;
      tx_bit  <= 1'b0;
      tx_strb <= 1'b0;
      tx_sof  <= 1'b0;
      tx_eof  <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      last_q  <= last_d;
      tx_bit  <= tx_bit_d;
      tx_strb <= strb_d;
      tx_sof  <= sof_d;
      tx_eof  <= eof_d;
      tx_busy <= busy_d;
    end
  end

  crc8_bit_engine u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (tx_bit),
    .crc    (crc_out)
  );

endmodule
